// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared types and helpers for the RedMulE tile-loop scheduler
// Purpose : scheduler state encoding, performance-counter bundle, W tile size helper.
// Contents: sched_state_e, sched_perf_t, tile_beats().
package redmule_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [31:0] cycles;
    logic [31:0] stall;
  } sched_perf_t;

  // A W tile has to fill every FMA pipeline slot of every engine row.
  function automatic int unsigned tile_beats(int unsigned num_pipe_regs, int unsigned height);
    return (num_pipe_regs + 1) * height;
  endfunction

endpackage

// File: rtl/redmule_tile_sched_if.sv
// rtl/redmule_tile_sched_if.sv - X/W/Z beat handshake bundle between scheduler and streamer
// Purpose : groups the three valid/ready beat channels.
// Ports   : master = scheduler (drives *_valid, samples *_ready);
//           slave  = streamer  (samples *_valid, drives *_ready).
interface redmule_tile_sched_if;
  logic x_valid;
  logic x_ready;
  logic w_valid;
  logic w_ready;
  logic z_valid;
  logic z_ready;

  modport master (output x_valid, w_valid, z_valid, input x_ready, w_ready, z_ready);
  modport slave  (input x_valid, w_valid, z_valid, output x_ready, w_ready, z_ready);
endinterface

// File: rtl/redmule_beat_cnt.sv
// rtl/redmule_beat_cnt.sv - valid/ready beat counter with terminal count and sync clear
// Purpose : raises valid while enabled until Count beats are accepted, then holds done.
// Ports   : clk_i, rst_ni (async active-low), clear_i (sync), en_i, ready_i,
//           valid_o (beat offered), done_o (Count beats accepted, including the
//           beat accepted this cycle).
module redmule_beat_cnt #(
  parameter int unsigned Count = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  input  logic ready_i,
  output logic valid_o,
  output logic done_o
);

  localparam int unsigned CW = $clog2(Count + 1);

  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          last;

  assign valid_o = en_i && !done_q;
  assign last    = valid_o && ready_i && (cnt_q == CW'(Count - 1));
  // Reporting done in the cycle of the final beat lets the scheduler advance
  // without an idle bubble between tiles.
  assign done_o  = done_q || last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (valid_o && ready_i) begin
      cnt_q <= cnt_q + CW'(1);
      if (last) done_q <= 1'b1;
    end
  end

endmodule

// File: rtl/redmule_tile_sched.sv
// rtl/redmule_tile_sched.sv - RedMulE tile-loop scheduler (m outer, k middle, n inner)
// Purpose : sequences X/W tile loads and Z tile stores toward the streamer.
// Ports   : clk_i, rst_ni (async active-low); clear_i, first_load_i, sched_rst_i,
//           cfg_valid_i, m/n/k_tiles_i from the controller; bus (master modport of
//           redmule_tile_sched_if); w_loaded_o, done_o, busy_o, m/n/k_idx_o.
// Option  : REDMULE_SCHED_PERF_EN adds perf_cycles_o and perf_stall_o.
module redmule_tile_sched
  import redmule_pkg::*;
#(
  parameter int unsigned Height      = 4,
  parameter int unsigned Width       = 8,
  parameter int unsigned NumPipeRegs = 3,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                first_load_i,
  input  logic                sched_rst_i,
  input  logic                cfg_valid_i,
  input  logic [CntWidth-1:0] m_tiles_i,
  input  logic [CntWidth-1:0] n_tiles_i,
  input  logic [CntWidth-1:0] k_tiles_i,
  redmule_tile_sched_if.master bus,
  output logic                w_loaded_o,
  output logic                done_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] m_idx_o,
  output logic [CntWidth-1:0] n_idx_o,
  output logic [CntWidth-1:0] k_idx_o
`ifdef REDMULE_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_cycles_o,
  output logic [31:0]         perf_stall_o
`endif
);

  localparam int unsigned Tile = tile_beats(NumPipeRegs, Height);

  sched_state_e        state_q, state_d;
  logic [CntWidth-1:0] m_cnt_q, n_cnt_q, k_cnt_q;
  logic [CntWidth-1:0] m_q, n_q, k_q, m_d, n_d, k_d;
  logic                w_loaded_q, done_q;
  logic                soft_clr, start, beat_clr, cnt_clr;
  logic                x_valid, w_valid, z_valid, x_done, w_done, z_done;
  logic                first_tile, w_first_done, zero_cfg;

  // Leaving FINISHED behaves exactly like a soft clear.
  assign soft_clr     = clear_i | sched_rst_i;
  assign start        = (state_q == IDLE) && first_load_i && cfg_valid_i;
  assign zero_cfg     = (m_tiles_i == '0) || (n_tiles_i == '0) || (k_tiles_i == '0);
  assign cnt_clr      = soft_clr | beat_clr;
  assign first_tile   = (m_q == '0) && (n_q == '0) && (k_q == '0);
  assign w_first_done = (state_q == LOAD) && first_tile && w_done;

  redmule_beat_cnt #(.Count(Width)) i_x_cnt (
    .clk_i, .rst_ni, .clear_i(cnt_clr), .en_i(state_q == LOAD),
    .ready_i(bus.x_ready), .valid_o(x_valid), .done_o(x_done)
  );

  redmule_beat_cnt #(.Count(Tile)) i_w_cnt (
    .clk_i, .rst_ni, .clear_i(cnt_clr), .en_i(state_q == LOAD),
    .ready_i(bus.w_ready), .valid_o(w_valid), .done_o(w_done)
  );

  redmule_beat_cnt #(.Count(Width)) i_z_cnt (
    .clk_i, .rst_ni, .clear_i(cnt_clr), .en_i(state_q == STORE),
    .ready_i(bus.z_ready), .valid_o(z_valid), .done_o(z_done)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    beat_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = zero_cfg ? DONE : LOAD;
      end
      LOAD: begin
        if (x_done && w_done) begin
          beat_clr = 1'b1;
          if (n_q != n_cnt_q - CntWidth'(1)) n_d = n_q + CntWidth'(1);
          else                               state_d = STORE;
        end
      end
      STORE: begin
        if (z_done) begin
          beat_clr = 1'b1;
          n_d      = '0;
          state_d  = LOAD;
          if (k_q != k_cnt_q - CntWidth'(1)) begin
            k_d = k_q + CntWidth'(1);
          end else begin
            k_d = '0;
            if (m_q == m_cnt_q - CntWidth'(1)) state_d = DONE;
            else                               m_d = m_q + CntWidth'(1);
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      {m_cnt_q, n_cnt_q, k_cnt_q} <= '0;
      {m_q, n_q, k_q} <= '0;
      w_loaded_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (soft_clr) begin
      state_q    <= IDLE;
      {m_cnt_q, n_cnt_q, k_cnt_q} <= '0;
      {m_q, n_q, k_q} <= '0;
      w_loaded_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      done_q  <= (state_q != DONE) && (state_d == DONE);
      if (start) begin
        m_cnt_q <= m_tiles_i;
        n_cnt_q <= n_tiles_i;
        k_cnt_q <= k_tiles_i;
      end
      if (w_first_done) w_loaded_q <= 1'b1;
    end
  end

  assign bus.x_valid = x_valid;
  assign bus.w_valid = w_valid;
  assign bus.z_valid = z_valid;
  // Combinational term makes w_loaded visible in the cycle of the last W beat.
  assign w_loaded_o  = w_loaded_q | w_first_done;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign m_idx_o     = m_q;
  assign n_idx_o     = n_q;
  assign k_idx_o     = k_q;

`ifdef REDMULE_SCHED_PERF_EN
  sched_perf_t perf_q;
  logic        stall;

  assign stall = (x_valid & ~bus.x_ready) | (w_valid & ~bus.w_ready) | (z_valid & ~bus.z_ready);

  // Counts only while tiles are moving, so values hold through DONE and IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (clear_i || (start && !sched_rst_i)) begin
      perf_q <= '0;
    end else if ((state_q == LOAD) || (state_q == STORE)) begin
      if (perf_q.cycles != '1)         perf_q.cycles <= perf_q.cycles + 32'd1;
      if (stall && perf_q.stall != '1) perf_q.stall  <= perf_q.stall + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q.cycles;
  assign perf_stall_o  = perf_q.stall;
`endif

endmodule
